// File: rtl/audio_pkg.sv
// Shared audio definitions for the I2S transmit path.
//   SAMPLE_W  : default bits per channel sample
//   LEFT/RIGHT: channel indices into a stereo sample (left = 0)
//   stereo_t  : packed stereo sample, [LEFT] and [RIGHT] words, two's complement
package audio_pkg;

  localparam int unsigned SAMPLE_W = 16;

  // Channel indices; one bit wide so they index a [1:0] dimension cleanly.
  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  typedef logic [1:0][SAMPLE_W-1:0] stereo_t;

endpackage : audio_pkg

// File: rtl/i2s_clk_gen.sv
// I2S bit-clock generator.
// Divides clk by 2*CLK_DIV to produce a registered bit clock and flags the
// clk edge on which that bit clock falls.
// Ports:
//   clk        : system clock
//   reset_n    : asynchronous active-low reset
//   en         : run enable; low parks the divider at 0 and the bit clock low
//   i2s_bclk   : registered bit clock
//   fall_evt_c : combinational strobe, high in the cycle whose clk edge
//                takes i2s_bclk from 1 to 0
module i2s_clk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic i2s_bclk,
  output logic fall_evt_c
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             bclk_q, bclk_d;
  logic             wrap_c;

  assign wrap_c = (div_cnt_q == DIV_LAST);

  // Divider next state: hold at zero while disabled, wrap and toggle otherwise.
  always_comb begin
    div_cnt_d = div_cnt_q;
    bclk_d    = bclk_q;
    if (!en) begin
      div_cnt_d = '0;
      bclk_d    = 1'b0;
    end else if (wrap_c) begin
      div_cnt_d = '0;
      bclk_d    = ~bclk_q;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

  // The upcoming edge toggles a high bit clock, i.e. it is a falling edge.
  assign fall_evt_c = en & wrap_c & bclk_q;
  assign i2s_bclk   = bclk_q;

endmodule : i2s_clk_gen

// File: rtl/i2s_tx.sv
// I2S stereo transmitter (standard I2S framing, one-BCLK word-select lead).
// A single-entry holding register with a pending flag decouples the sample
// strobe from the frame rate; each frame load takes the pending sample or
// sends silence and flags an underrun.
// Ports:
//   clk        : system clock, all logic on posedge
//   reset_n    : asynchronous active-low reset
//   audio_in   : stereo sample, [0]=left, [1]=right
//   sample_en  : one-clk strobe, audio_in valid
//   tx_en      : transmit enable, low = interface idle
//   i2s_bclk   : bit clock
//   i2s_lrclk  : word select, 0=left, 1=right
//   i2s_sdata  : serial data, MSB first
//   frame_sync : pulse when a frame is loaded into the shifter
//   underrun   : pulse when a frame loads with no pending sample
//   overrun    : pulse when sample_en overwrites an unconsumed sample
module i2s_tx
  import audio_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0][DATA_W-1:0] audio_in,
  input  logic                   sample_en,
  input  logic                   tx_en,
  output logic                   i2s_bclk,
  output logic                   i2s_lrclk,
  output logic                   i2s_sdata,
  output logic                   frame_sync,
  output logic                   underrun,
  output logic                   overrun
);

  localparam int unsigned FRAME_W = 2 * DATA_W;
  localparam int unsigned BIT_W   = $clog2(FRAME_W);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
  // Word select is high one bit early, covering the last left bit and all
  // but the last right bit.
  localparam logic [BIT_W-1:0] LR_LO = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] LR_HI = BIT_W'(FRAME_W - 2);

  logic                   fall_evt_c;
  logic                   frame_load_c;

  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0]     shifter_q, shifter_d;
  logic [1:0][DATA_W-1:0] holding_q, holding_d;
  logic                   pending_q, pending_d;
  logic                   lrclk_q, lrclk_d;
  logic                   frame_sync_q, frame_sync_d;
  logic                   underrun_q, underrun_d;
  logic                   overrun_q, overrun_d;

  i2s_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (tx_en),
    .i2s_bclk   (i2s_bclk),
    .fall_evt_c (fall_evt_c)
  );

  // A frame loads on the fall event that wraps the bit counter.
  assign frame_load_c = fall_evt_c & (bit_cnt_q == BIT_LAST);

  // Bit counter, shifter, word select and the sample handshake.
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shifter_d    = shifter_q;
    holding_d    = holding_q;
    pending_d    = pending_q;
    lrclk_d      = lrclk_q;
    frame_sync_d = 1'b0;
    underrun_d   = 1'b0;
    overrun_d    = 1'b0;

    if (!tx_en) begin
      // Park so that re-enabling replays the post-reset timing.
      bit_cnt_d = BIT_LAST;
      shifter_d = '0;
      lrclk_d   = 1'b0;
    end else if (fall_evt_c) begin
      bit_cnt_d = frame_load_c ? '0 : bit_cnt_q + BIT_W'(1);
      lrclk_d   = (bit_cnt_d >= LR_LO) && (bit_cnt_d <= LR_HI);
      if (frame_load_c) begin
        frame_sync_d = 1'b1;
        if (pending_q) begin
          shifter_d = {holding_q[LEFT], holding_q[RIGHT]};
        end else begin
          shifter_d  = '0;
          underrun_d = 1'b1;
        end
      end else begin
        shifter_d = {shifter_q[FRAME_W-2:0], 1'b0};
      end
    end

    // The load consumes the old holding value before a same-cycle write.
    if (frame_load_c) begin
      pending_d = 1'b0;
    end
    if (sample_en) begin
      holding_d = audio_in;
      pending_d = 1'b1;
      overrun_d = pending_q & ~frame_load_c;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_q    <= BIT_LAST;
      shifter_q    <= '0;
      holding_q    <= '0;
      pending_q    <= 1'b0;
      lrclk_q      <= 1'b0;
      frame_sync_q <= 1'b0;
      underrun_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      shifter_q    <= shifter_d;
      holding_q    <= holding_d;
      pending_q    <= pending_d;
      lrclk_q      <= lrclk_d;
      frame_sync_q <= frame_sync_d;
      underrun_q   <= underrun_d;
      overrun_q    <= overrun_d;
    end
  end

  assign i2s_lrclk  = lrclk_q;
  assign i2s_sdata  = shifter_q[FRAME_W-1];
  assign frame_sync = frame_sync_q;
  assign underrun   = underrun_q;
  assign overrun    = overrun_q;

endmodule : i2s_tx
